// File: rtl/control_sequencer_pkg.sv
// Purpose : shared opcode/ALU encodings, state encodings and decode helpers for control_sequencer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package control_sequencer_pkg;

  localparam int NREG_DEF = 16;
  localparam int OPW_DEF  = 5;
  localparam int RSW_DEF  = 4;

  // IR opcode field values (IR[31:27])
  localparam logic [4:0] OPC_ADD  = 5'b00000;
  localparam logic [4:0] OPC_SUB  = 5'b00001;
  localparam logic [4:0] OPC_AND  = 5'b00010;
  localparam logic [4:0] OPC_OR   = 5'b00011;
  localparam logic [4:0] OPC_ROR  = 5'b00100;
  localparam logic [4:0] OPC_ROL  = 5'b00101;
  localparam logic [4:0] OPC_SHR  = 5'b00110;
  localparam logic [4:0] OPC_SHL  = 5'b00111;
  localparam logic [4:0] OPC_SHRA = 5'b01000;
  localparam logic [4:0] OPC_MUL  = 5'b01110;
  localparam logic [4:0] OPC_DIV  = 5'b01111;
  localparam logic [4:0] OPC_NEG  = 5'b10000;
  localparam logic [4:0] OPC_NOT  = 5'b10001;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // ALU OP bus values
  localparam logic [4:0] ALU_NOP  = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_ROR  = 5'b00101;
  localparam logic [4:0] ALU_ROL  = 5'b00110;
  localparam logic [4:0] ALU_SHR  = 5'b00111;
  localparam logic [4:0] ALU_SHL  = 5'b01000;
  localparam logic [4:0] ALU_SHRA = 5'b01001;
  localparam logic [4:0] ALU_MUL  = 5'b01111;
  localparam logic [4:0] ALU_DIV  = 5'b10000;
  localparam logic [4:0] ALU_NEG  = 5'b10001;
  localparam logic [4:0] ALU_NOT  = 5'b10010;

  // Control state encodings
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  // Single-bit datapath strobes, grouped so the decode has one default assignment.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
  } strobes_t;

  // Opcode -> ALU OP; ALU_NOP marks an opcode with no ALU execute sequence.
  function automatic logic [4:0] alu_op(input logic [4:0] opc);
    case (opc)
      OPC_ADD:  alu_op = ALU_ADD;
      OPC_SUB:  alu_op = ALU_SUB;
      OPC_AND:  alu_op = ALU_AND;
      OPC_OR:   alu_op = ALU_OR;
      OPC_ROR:  alu_op = ALU_ROR;
      OPC_ROL:  alu_op = ALU_ROL;
      OPC_SHR:  alu_op = ALU_SHR;
      OPC_SHL:  alu_op = ALU_SHL;
      OPC_SHRA: alu_op = ALU_SHRA;
      OPC_MUL:  alu_op = ALU_MUL;
      OPC_DIV:  alu_op = ALU_DIV;
      OPC_NEG:  alu_op = ALU_NEG;
      OPC_NOT:  alu_op = ALU_NOT;
      default:  alu_op = ALU_NOP;
    endcase
  endfunction

  function automatic logic opc_is_rtype(input logic [4:0] opc);
    return alu_op(opc) != ALU_NOP;
  endfunction

  function automatic logic opc_is_muldiv(input logic [4:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

  function automatic logic opc_is_unary(input logic [4:0] opc);
    return (opc == OPC_NEG) || (opc == OPC_NOT);
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// Purpose : register-select field -> one-hot bus select, gated by an enable.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_sel (RSW) field, i_en enable, o_onehot (NREG) one-hot select, all-zero when disabled.
module control_sequencer_reg_select_decoder #(
  parameter int RSW  = 4,
  parameter int NREG = 16
) (
  input  logic [RSW-1:0]  i_sel,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    // Out-of-range selects (NREG < 2**RSW) decode to no register.
    if (i_en && (int'(i_sel) < NREG)) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose : hardwired fetch + R-type execute sequencer driving the 32-bit datapath strobes.
// Latency : 6 cycles per instruction (T0-T5), 7 for MUL/DIV; outputs are a Moore decode of state+IR.
// Backpressure: none; Run gates starting the next instruction, Clear aborts synchronously.
// Ports   : Clock, Clear (sync active-high), Run, IR in; datapath strobes, Rin/Rout one-hot,
//           OP, InstrDone pulse and Halted out.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int OPW  = OPW_DEF,
  parameter int RSW  = RSW_DEF
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            Run,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            ZLowin,
  output logic            ZHighin,
  output logic            ZLowout,
  output logic            ZHighout,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  OP,
  output logic            InstrDone,
  output logic            Halted
);

  logic [3:0]     r_state;
  logic [3:0]     w_next;

  logic [4:0]     w_opc;
  logic [RSW-1:0] w_ra;
  logic [RSW-1:0] w_rb;
  logic [RSW-1:0] w_rc;
  logic           w_unused_ir;

  logic           w_rtype;
  logic           w_muldiv;
  logic           w_unary;
  logic           w_halt_opc;

  strobes_t       w_stb;
  logic           w_rout_en;
  logic [RSW-1:0] w_rout_sel;
  logic           w_rin_en;
  logic [4:0]     w_op;
  logic           w_done;

  assign w_opc       = IR[31:27];
  assign w_ra        = IR[26:23];
  assign w_rb        = IR[22:19];
  assign w_rc        = IR[18:15];
  assign w_unused_ir = ^IR[14:0];

  assign w_rtype    = opc_is_rtype(w_opc);
  assign w_muldiv   = opc_is_muldiv(w_opc);
  assign w_unary    = opc_is_unary(w_opc);
  assign w_halt_opc = (w_opc == OPC_HALT);

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Run is only consulted where an instruction can start, so a drop mid-instruction
  // lets it finish.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = Run ? ST_T0 : ST_IDLE;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = ST_T3;
      ST_T3: begin
        if (w_halt_opc)   w_next = ST_HALT;
        else if (w_rtype) w_next = ST_T4;
        else              w_next = Run ? ST_T0 : ST_IDLE;
      end
      ST_T4:   w_next = ST_T5;
      ST_T5:   w_next = w_muldiv ? ST_T6 : (Run ? ST_T0 : ST_IDLE);
      ST_T6:   w_next = Run ? ST_T0 : ST_IDLE;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stb      = '0;
    w_rout_en  = 1'b0;
    w_rout_sel = w_rb;
    w_rin_en   = 1'b0;
    w_op       = ALU_NOP;
    w_done     = 1'b0;
    case (r_state)
      ST_T0: begin
        w_stb.pc_out  = 1'b1;
        w_stb.mar_in  = 1'b1;
        w_stb.inc_pc  = 1'b1;
        w_stb.zlow_in = 1'b1;
      end
      ST_T1: begin
        w_stb.zlow_out = 1'b1;
        w_stb.pc_in    = 1'b1;
        w_stb.read     = 1'b1;
        w_stb.mdr_in   = 1'b1;
      end
      ST_T2: begin
        w_stb.mdr_out = 1'b1;
        w_stb.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (w_rtype) begin
          w_rout_en  = 1'b1;
          w_rout_sel = w_rb;
          w_stb.y_in = 1'b1;
        end else if (!w_halt_opc) begin
          // Undefined opcode retires as a no-op.
          w_done = 1'b1;
        end
      end
      ST_T4: begin
        w_op           = alu_op(w_opc);
        w_stb.zlow_in  = 1'b1;
        w_stb.zhigh_in = w_muldiv;
        w_rout_en      = 1'b1;
        // Unary ops take their only operand from Rb; Y holds it too but the ALU ignores Y.
        w_rout_sel     = w_unary ? w_rb : w_rc;
      end
      ST_T5: begin
        w_stb.zlow_out = 1'b1;
        if (w_muldiv) begin
          w_stb.lo_in = 1'b1;
        end else begin
          w_rin_en = 1'b1;
          w_done   = 1'b1;
        end
      end
      ST_T6: begin
        w_stb.zhigh_out = 1'b1;
        w_stb.hi_in     = 1'b1;
        w_done          = 1'b1;
      end
      default: begin
      end
    endcase
  end

  control_sequencer_reg_select_decoder #(
    .RSW  (RSW),
    .NREG (NREG)
  ) u_rout_dec (
    .i_sel    (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

  control_sequencer_reg_select_decoder #(
    .RSW  (RSW),
    .NREG (NREG)
  ) u_rin_dec (
    .i_sel    (w_ra),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

  assign PCout     = w_stb.pc_out;
  assign MARin     = w_stb.mar_in;
  assign IncPC     = w_stb.inc_pc;
  assign PCin      = w_stb.pc_in;
  assign Read      = w_stb.read;
  assign MDRin     = w_stb.mdr_in;
  assign MDRout    = w_stb.mdr_out;
  assign IRin      = w_stb.ir_in;
  assign Yin       = w_stb.y_in;
  assign ZLowin    = w_stb.zlow_in;
  assign ZHighin   = w_stb.zhigh_in;
  assign ZLowout   = w_stb.zlow_out;
  assign ZHighout  = w_stb.zhigh_out;
  assign HIin      = w_stb.hi_in;
  assign LOin      = w_stb.lo_in;
  assign OP        = OPW'(w_op);
  assign InstrDone = w_done;
  assign Halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose : directed self-checking bench for control_sequencer.
// Latency : n/a.
// Backpressure: n/a.
module tb_control_sequencer;

  logic        clk;
  logic        Clear;
  logic        Run;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  OP;
  logic        InstrDone, Halted;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  // Strobe bit positions in the observed vector (MSB = PCout ... LSB = LOin)
  localparam logic [14:0] S_PCOUT  = 15'h4000;
  localparam logic [14:0] S_MARIN  = 15'h2000;
  localparam logic [14:0] S_INCPC  = 15'h1000;
  localparam logic [14:0] S_PCIN   = 15'h0800;
  localparam logic [14:0] S_READ   = 15'h0400;
  localparam logic [14:0] S_MDRIN  = 15'h0200;
  localparam logic [14:0] S_MDROUT = 15'h0100;
  localparam logic [14:0] S_IRIN   = 15'h0080;
  localparam logic [14:0] S_YIN    = 15'h0040;
  localparam logic [14:0] S_ZLIN   = 15'h0020;
  localparam logic [14:0] S_ZHIN   = 15'h0010;
  localparam logic [14:0] S_ZLOUT  = 15'h0008;
  localparam logic [14:0] S_ZHOUT  = 15'h0004;
  localparam logic [14:0] S_HIIN   = 15'h0002;
  localparam logic [14:0] S_LOIN   = 15'h0001;

  localparam logic [14:0] T0_S = S_PCOUT | S_MARIN | S_INCPC | S_ZLIN;
  localparam logic [14:0] T1_S = S_ZLOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [14:0] T2_S = S_MDROUT | S_IRIN;

  logic [53:0] obs;
  assign obs = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
                ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
                Rin, Rout, OP, InstrDone, Halted};

  control_sequencer dut (
    .Clock     (clk),
    .Clear     (Clear),
    .Run       (Run),
    .IR        (IR),
    .PCout     (PCout),
    .MARin     (MARin),
    .IncPC     (IncPC),
    .PCin      (PCin),
    .Read      (Read),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .ZLowin    (ZLowin),
    .ZHighin   (ZHighin),
    .ZLowout   (ZLowout),
    .ZHighout  (ZHighout),
    .HIin      (HIin),
    .LOin      (LOin),
    .Rin       (Rin),
    .Rout      (Rout),
    .OP        (OP),
    .InstrDone (InstrDone),
    .Halted    (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [53:0] ex(input logic [14:0] s, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic [4:0] op,
                                     input logic done, input logic halt);
    return {s, rin, rout, op, done, halt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [53:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic fetch_checks(input string tag);
    chk({tag, "_T0"}, ex(T0_S, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0));
    tick();
    chk({tag, "_T1"}, ex(T1_S, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0));
    tick();
    chk({tag, "_T2"}, ex(T2_S, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0));
  endtask

  initial begin
    Clear = 1'b1;
    Run   = 1'b0;
    IR    = 32'h0;

    // 1. Reset, then IDLE with all outputs low
    tick();
    tick();
    chk("reset", 54'h0);
    Clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold", 54'h0);
    end

    // 2. shra R1,R3,R5
    IR  = 32'h409A8000;
    Run = 1'b1;
    tick();
    fetch_checks("shra");
    tick();
    chk("shra_T3", ex(S_YIN, 16'h0, 16'h0008, 5'b0, 1'b0, 1'b0));
    tick();
    chk("shra_T4", ex(S_ZLIN, 16'h0, 16'h0020, 5'b01001, 1'b0, 1'b0));
    tick();
    chk("shra_T5", ex(S_ZLOUT, 16'h0002, 16'h0, 5'b0, 1'b1, 1'b0));
    done_cyc = cyc;
    tick();

    // 3. mul R6,R2,R4 (IR updates during T0 of the new instruction)
    IR = {5'b01110, 4'd6, 4'd2, 4'd4, 15'd0};
    fetch_checks("mul");
    tick();
    chk("mul_T3", ex(S_YIN, 16'h0, 16'h0004, 5'b0, 1'b0, 1'b0));
    tick();
    chk("mul_T4", ex(S_ZLIN | S_ZHIN, 16'h0, 16'h0010, 5'b01111, 1'b0, 1'b0));
    tick();
    chk("mul_T5", ex(S_ZLOUT | S_LOIN, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0));
    tick();
    chk("mul_T6", ex(S_ZHOUT | S_HIIN, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0));
    n_assert++;
    assert (cyc - done_cyc == 7) else begin
      n_fail++;
      $error("FAIL mul_period observed=%0d expected=7", cyc - done_cyc);
    end
    tick();

    // 4. add R7,R8,R9 with Run dropped during T2
    IR = {5'b00000, 4'd7, 4'd8, 4'd9, 15'd0};
    fetch_checks("add");
    Run = 1'b0;
    tick();
    chk("add_T3", ex(S_YIN, 16'h0, 16'h0100, 5'b0, 1'b0, 1'b0));
    tick();
    chk("add_T4", ex(S_ZLIN, 16'h0, 16'h0200, 5'b00001, 1'b0, 1'b0));
    tick();
    chk("add_T5", ex(S_ZLOUT, 16'h0080, 16'h0, 5'b0, 1'b1, 1'b0));
    tick();
    chk("add_idle1", 54'h0);
    tick();
    chk("add_idle2", 54'h0);

    // 5. sub R1,R2,R3 aborted by Clear in T4
    IR  = {5'b00001, 4'd1, 4'd2, 4'd3, 15'd0};
    Run = 1'b1;
    tick();
    fetch_checks("sub");
    tick();
    chk("sub_T3", ex(S_YIN, 16'h0, 16'h0004, 5'b0, 1'b0, 1'b0));
    tick();
    chk("sub_T4", ex(S_ZLIN, 16'h0, 16'h0008, 5'b00010, 1'b0, 1'b0));
    Clear = 1'b1;
    tick();
    chk("sub_abort", 54'h0);
    Clear = 1'b0;
    Run   = 1'b0;
    tick();
    chk("sub_abort_idle", 54'h0);

    // Undefined opcode retires at T3 with only InstrDone; Run low sends it to IDLE
    IR  = {5'b01001, 4'd2, 4'd3, 4'd4, 15'd0};
    Run = 1'b1;
    tick();
    fetch_checks("undef");
    Run = 1'b0;
    tick();
    chk("undef_T3", ex(15'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0));
    tick();
    chk("undef_idle", 54'h0);

    // 6. HALT: no strobes in T3, Halted held with Run high, only Clear exits
    IR  = {5'b11011, 4'd0, 4'd0, 4'd0, 15'd0};
    Run = 1'b1;
    tick();
    fetch_checks("halt");
    tick();
    chk("halt_T3", 54'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold", ex(15'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1));
    end
    Clear = 1'b1;
    tick();
    chk("halt_clear", 54'h0);
    Clear = 1'b0;
    Run   = 1'b0;
    tick();
    chk("halt_idle", 54'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
